shift_reg_sequencer: RTL
========================

// Module: shift_reg_sequencer
// PURPOSE
//  Command sequencer sitting directly upstream of the 8-bit Shift_Register; drives its i/s/r control pins.
//  Accepts one command per valid/ready handshake (load, shift-left N, shift-right N, load-then-shift-right N).
//  Steps the register one operation per clock, then reads back the register's parallel output as result.
//  Replaces hand-driven s/i/r sequencing with a cycle-exact, counted controller.
// PARAMETERS
//  WIDTH  8  register width; also the maximum shift count
//  CNT_W  4  width of cmd_count; must be >= clog2(WIDTH)+1
// PORTS
//  clk          in   1      single clock; all state changes on rising edge
//  reset        in   1      asynchronous, active-low reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      sequencer can accept; a command transfers when cmd_valid & cmd_ready at an edge
//  cmd_op       in   2      00 LOAD, 01 SHL_N, 10 SHR_N, 11 LOAD_SHR
//  cmd_data     in   WIDTH  parallel load value (used by LOAD and LOAD_SHR)
//  cmd_count    in   CNT_W  number of shift cycles; values > WIDTH clamp to WIDTH
//  cmd_fill     in   1      serial bit driven on sr_r during right shifts
//  sr_i         out  WIDTH  to Shift_Register parallel input
//  sr_s         out  2      to Shift_Register mode: 00 hold, 01 shift left (LSB<-0), 10 shift right (MSB<-r), 11 load
//  sr_r         out  1      to Shift_Register serial input
//  sr_o         in   WIDTH  from Shift_Register parallel output
//  busy         out  1      high in every state except IDLE
//  done         out  1      one-cycle pulse; result is valid in this cycle
//  result       out  WIDTH  register value captured at end of command; held until next done
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; sr_s=00, sr_i=0, sr_r=0, result=0, done=0, busy=0, cmd_ready=0.
//  cmd_ready registered: rises on first clk edge after reset deasserts; then =1 exactly when state==IDLE.
//  sr_i/sr_s/sr_r registered: they hold the state's value for that whole cycle; the register samples them at the edge ending it.
//  FSM states: IDLE, LOAD, SHIFT, SETTLE, DONE.
//   IDLE: sr_s=00. On handshake: latch op, data, fill, cnt=min(cmd_count,WIDTH).
//    -> LOAD for LOAD/LOAD_SHR; -> SHIFT for SHL_N/SHR_N with cnt>0; -> SETTLE if cnt==0.
//   LOAD: exactly 1 cycle, sr_s=11, sr_i=data. -> SHIFT if op==LOAD_SHR and cnt>0, else -> SETTLE.
//    LOAD ignores cmd_count.
//   SHIFT: exactly cnt cycles; sr_s=01 (SHL_N) or 10 (SHR_N/LOAD_SHR); sr_r=fill on right shifts, 0 otherwise.
//    Down-counter decrements each cycle; -> SETTLE after the cycle with cnt==1.
//   SETTLE: 1 cycle, sr_s=00; sr_o now reflects the final value; result<=sr_o at the edge ending SETTLE.
//   DONE: 1 cycle, done=1, sr_s=00, cmd_ready=0. -> IDLE.
//  Latency, handshake edge to done=1: 3 cycles (LOAD, or any op with cnt 0).
//   SHL_N/SHR_N: N+2 cycles. LOAD_SHR: N+3 cycles.
//  SHL_N/SHR_N act on whatever value the register already holds.
//  cmd_valid while busy: ignored, no transfer. Back-to-back: next command accepted in the IDLE cycle after DONE.
//  Reset mid-command: immediate return to reset values; no done pulse; the partial command is discarded.
//  Outside states LOAD and SHIFT, sr_s is always 00, so the register holds.
// STRUCTURE
//  Shared package shift_seq_pkg holds:
//   - op codes (OP_LOAD/OP_SHL/OP_SHR/OP_LOAD_SHR)
//   - sr_s mode codes (SR_HOLD/SR_SHL/SR_SHR/SR_LOAD)
//   - FSM state encodings
//  One sub-module: shift_down_counter (CNT_W-bit loadable down-counter with load, dec and zero/one flags).
//  FSM, output registers and result capture live in the top module.
// TESTING (bench instantiates Shift_Register; its active-high reset is driven by ~reset)
//  1 Reset: hold reset=0, toggle clk -> sr_s=00, sr_i=00, sr_r=0, result=00, done=0, cmd_ready=0; release -> cmd_ready=1 after 1 edge.
//  2 LOAD data=8'hA5, count=5 -> one cycle with sr_s=11/sr_i=A5, no shift cycles; done 3 cycles after handshake; result=8'hA5.
//  3 Following 2: SHL_N count=1 -> exactly one sr_s=01 cycle; result=8'h4A; done 3 cycles after handshake.
//  4 LOAD_SHR data=8'hA5, count=3, fill=1 -> 3 cycles sr_s=10/sr_r=1; result=8'hF4; done at cycle 6.
//  5 LOAD_SHR data=8'hFF, count=12, fill=0 -> count clamps to 8; exactly 8 shift cycles; result=8'h00.
//  6 Reset asserted during SHIFT cycle 2 of case 4 -> all outputs to reset values at once; no done.
//    cmd_valid held high through busy -> no extra transfer.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift-register command sequencer:
// command op codes, Shift_Register mode codes and FSM state encodings.
package shift_seq_pkg;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_SHL      = 2'b01;
  localparam logic [1:0] OP_SHR      = 2'b10;
  localparam logic [1:0] OP_LOAD_SHR = 2'b11;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_SHL  = 2'b01;
  localparam logic [1:0] SR_SHR  = 2'b10;
  localparam logic [1:0] SR_LOAD = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic logic is_right_op(input logic [1:0] op);
    return (op == OP_SHR) || (op == OP_LOAD_SHR);
  endfunction

endpackage

// File: rtl/shift_down_counter.sv
// Loadable down-counter that counts the remaining shift cycles of a command.
// Saturates at zero; zero_o/one_o flag the terminal values for the FSM.
module shift_down_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o,
  output logic             one_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_register.sv
// Downstream 8-bit Shift_Register: hold / shift-left (LSB<-0) / shift-right (MSB<-r) / load.
module Shift_Register #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i,
  input  logic [1:0]       s,
  input  logic             r,
  output logic [WIDTH-1:0] o
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o <= '0;
    end else begin
      case (s)
        2'b01:   o <= {o[WIDTH-2:0], 1'b0};
        2'b10:   o <= {r, o[WIDTH-1:1]};
        2'b11:   o <= i;
        default: o <= o;
      endcase
    end
  end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Counted command sequencer driving the Shift_Register i/s/r pins one operation per clock,
// then capturing the register's parallel output as the command result.
module shift_reg_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  output logic [WIDTH-1:0] sr_i,
  output logic [1:0]       sr_s,
  output logic             sr_r,
  input  logic [WIDTH-1:0] sr_o,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q;
  logic             fill_q;
  logic             cmd_ready_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] sr_i_q, sr_i_d;
  logic [1:0]       sr_s_q, sr_s_d;
  logic             sr_r_q, sr_r_d;

  logic             handshake;
  logic [CNT_W-1:0] cnt_clamped;
  logic             cnt_load, cnt_dec, cnt_zero, cnt_one;
  logic [1:0]       op_eff;
  logic             fill_eff;

  assign handshake   = cmd_valid && cmd_ready_q;
  assign cnt_clamped = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count;

  // Pin outputs are registered from the next state, so on the accepting edge the
  // op/fill registers are not yet loaded and the live command fields are used instead.
  assign op_eff   = (state_q == ST_IDLE) ? cmd_op   : op_q;
  assign fill_eff = (state_q == ST_IDLE) ? cmd_fill : fill_q;

  shift_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (cnt_load),
    .dec_i   (cnt_dec),
    .value_i (cnt_clamped),
    .zero_o  (cnt_zero),
    .one_o   (cnt_one)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          cnt_load = 1'b1;
          if ((cmd_op == OP_LOAD) || (cmd_op == OP_LOAD_SHR)) begin
            state_d = ST_LOAD;
          end else if (cnt_clamped == '0) begin
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_LOAD: begin
        state_d = ((op_q == OP_LOAD_SHR) && !cnt_zero) ? ST_SHIFT : ST_SETTLE;
      end
      ST_SHIFT: begin
        cnt_dec = 1'b1;
        if (cnt_one) begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sr_s_d = SR_HOLD;
    sr_i_d = '0;
    sr_r_d = 1'b0;
    case (state_d)
      ST_LOAD: begin
        sr_s_d = SR_LOAD;
        sr_i_d = cmd_data;
      end
      ST_SHIFT: begin
        if (is_right_op(op_eff)) begin
          sr_s_d = SR_SHR;
          sr_r_d = fill_eff;
        end else begin
          sr_s_d = SR_SHL;
        end
      end
      default: ;
    endcase
  end

  assign result_d = (state_q == ST_SETTLE) ? sr_o : result_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOAD;
      fill_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      sr_i_q      <= '0;
      sr_s_q      <= SR_HOLD;
      sr_r_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      result_q    <= result_d;
      sr_i_q      <= sr_i_d;
      sr_s_q      <= sr_s_d;
      sr_r_q      <= sr_r_d;
      if (handshake) begin
        op_q   <= cmd_op;
        fill_q <= cmd_fill;
      end
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign sr_i      = sr_i_q;
  assign sr_s      = sr_s_q;
  assign sr_r      = sr_r_q;

endmodule
